// File: rtl/dc_ipu_filter_outer_product_nxm.sv
// Filter outer-product stage: builds the TAPS_X x TAPS_Y separable weight
// matrix wx[i]*wy[j] with optional round-half-up and saturation. Texels,
// sideband and saturation flags ride the same elastic valid/ready pipeline
// as the products, so they can never fall out of lockstep.
module dc_ipu_filter_outer_product_nxm #(
  parameter int RGB_WIDTH          = 24,
  parameter int TAPS_X             = 4,
  parameter int TAPS_Y             = 4,
  parameter int WEIGHT_WIDTH       = 12,
  parameter int WEIGHT_FRACT_WIDTH = 10,
  parameter int MUL_LATENCY        = 2,
  parameter int ROUND_MODE         = 0,
  parameter int SATURATE           = 1,
  parameter int USER_WIDTH         = 2
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 clr,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [TAPS_X-1:0][TAPS_Y-1:0][RGB_WIDTH-1:0]         in_texel_matrix,
  input  logic [TAPS_X-1:0][WEIGHT_WIDTH-1:0]                  weights_x,
  input  logic [TAPS_Y-1:0][WEIGHT_WIDTH-1:0]                  weights_y,
  input  logic [USER_WIDTH-1:0]                                in_user,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [TAPS_X-1:0][TAPS_Y-1:0][RGB_WIDTH-1:0]         out_texel_matrix,
  output logic [TAPS_X-1:0][TAPS_Y-1:0][WEIGHT_WIDTH-1:0]      weights_matrix,
  output logic [USER_WIDTH-1:0]                                out_user,
  output logic                                                 out_sat,
  output logic signed [WEIGHT_WIDTH+$clog2(TAPS_X*TAPS_Y)-1:0] out_weight_sum
);

  localparam int W  = WEIGHT_WIDTH;
  localparam int F  = WEIGHT_FRACT_WIDTH;
  localparam int L  = MUL_LATENCY;
  localparam int PW = 2 * W + 1;
  localparam int SW = WEIGHT_WIDTH + $clog2(TAPS_X * TAPS_Y);

  // One extra guard bit above the full product so the rounding bias can never overflow
  localparam logic signed [PW-1:0] RoundBias = (ROUND_MODE != 0) ? (PW'(1) <<< (F - 1)) : '0;
  localparam logic signed [PW-1:0] MaxVal    = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] MinVal    = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef logic [TAPS_X-1:0][TAPS_Y-1:0][W-1:0]         wmat_t;
  typedef logic [TAPS_X-1:0][TAPS_Y-1:0][RGB_WIDTH-1:0] tmat_t;

  wmat_t                 weight_q [L];
  tmat_t                 texel_q  [L];
  logic [USER_WIDTH-1:0] user_q   [L];
  logic [L-1:0]          sat_q;
  logic [L-1:0]          valid_q;
  logic [L-1:0]          stageReady;

  wmat_t                 weight_d;
  logic                  sat_d;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shifted;
  logic                  overflow;
  logic                  chainOpen;
  logic signed [SW-1:0]  sumAcc;

  // Stage-0 arithmetic: product, optional rounding bias, shift, clamp or wrap, overflow flags
  always_comb begin
    weight_d = '0;
    sat_d    = 1'b0;
    prod     = '0;
    shifted  = '0;
    overflow = 1'b0;
    for (int i = 0; i < TAPS_X; i++) begin
      for (int j = 0; j < TAPS_Y; j++) begin
        prod     = PW'($signed(weights_x[i])) * PW'($signed(weights_y[j]));
        shifted  = (prod + RoundBias) >>> F;
        overflow = (shifted > MaxVal) || (shifted < MinVal);
        if (SATURATE != 0 && shifted > MaxVal) begin
          weight_d[i][j] = MaxVal[W-1:0];
        end else if (SATURATE != 0 && shifted < MinVal) begin
          weight_d[i][j] = MinVal[W-1:0];
        end else begin
          weight_d[i][j] = shifted[W-1:0];
        end
        sat_d = sat_d | overflow;
      end
    end
  end

  // A stage may load when some stage at or below it is empty, or the output is being taken
  always_comb begin
    stageReady = '0;
    chainOpen  = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      chainOpen     = chainOpen || !valid_q[k];
      stageReady[k] = chainOpen;
    end
  end

  assign in_ready = stageReady[0] && !clr && !reset;

  // Shared valid chain; clr drops every valid bit but leaves data registers untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      sat_q   <= '0;
      for (int k = 0; k < L; k++) begin
        weight_q[k] <= '0;
        texel_q[k]  <= '0;
        user_q[k]   <= '0;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else begin
      if (stageReady[0]) begin
        valid_q[0]  <= in_valid;
        weight_q[0] <= weight_d;
        texel_q[0]  <= in_texel_matrix;
        user_q[0]   <= in_user;
        sat_q[0]    <= sat_d;
      end
      for (int k = 1; k < L; k++) begin
        if (stageReady[k]) begin
          valid_q[k]  <= valid_q[k-1];
          weight_q[k] <= weight_q[k-1];
          texel_q[k]  <= texel_q[k-1];
          user_q[k]   <= user_q[k-1];
          sat_q[k]    <= sat_q[k-1];
        end
      end
    end
  end

  // Sum of the final matrix elements; the width leaves room for every element at full scale
  always_comb begin
    sumAcc = '0;
    for (int i = 0; i < TAPS_X; i++) begin
      for (int j = 0; j < TAPS_Y; j++) begin
        sumAcc = sumAcc + SW'($signed(weight_q[L-1][i][j]));
      end
    end
  end

  assign out_valid        = valid_q[L-1];
  assign weights_matrix   = weight_q[L-1];
  assign out_texel_matrix = texel_q[L-1];
  assign out_user         = user_q[L-1];
  assign out_sat          = sat_q[L-1];
  assign out_weight_sum   = sumAcc;

endmodule

// File: tb/tb_dc_ipu_filter_outer_product_nxm.sv
// Bench for the outer-product stage: a default 4x4 instance for arithmetic,
// backpressure, flush and reset, plus two 2x6 instances (round+wrap with
// latency 1, truncate+saturate with latency 4) driven from one shared bus.
module tb_dc_ipu_filter_outer_product_nxm;

  logic clk = 1'b0;
  logic reset;
  logic clr;
  int   edgeCnt = 0;
  int   compareCount = 0;
  int   mismatchCount = 0;

  // default instance signals
  logic                        aValid, aReady, aOutValid, aOutReady, aSat;
  logic [3:0][3:0][23:0]       aTex, aOutTex;
  logic [3:0][11:0]            aWx, aWy;
  logic [1:0]                  aUser, aOutUser;
  logic [3:0][3:0][11:0]       aWm;
  logic signed [15:0]          aSum;

  // shared bus for the two 2x6 instances
  logic                        bValid, bcOutReady;
  logic [1:0][5:0][23:0]       bTex;
  logic [1:0][11:0]            bWx;
  logic [5:0][11:0]            bWy;
  logic [3:0]                  bUser;
  logic                        bReady, bOutValid, bSat, cReady, cOutValid, cSat;
  logic [1:0][5:0][23:0]       bOutTex, cOutTex;
  logic [1:0][5:0][11:0]       bWm, cWm;
  logic [3:0]                  bOutUser, cOutUser;
  logic signed [15:0]          bSum, cSum;

  typedef struct {
    int   wx0, wxR, wy0, wyR;
    int   e00, e01, e10, e11;
    logic eSat;
    int   eSum;
  } vec_t;

  vec_t vecA [7];
  vec_t vecB [4];
  vec_t vecC [4];

  always #5 clk = ~clk;

  // cycle stamp used for latency and throughput checks
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  dc_ipu_filter_outer_product_nxm dutA (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(aValid), .in_ready(aReady), .in_texel_matrix(aTex),
    .weights_x(aWx), .weights_y(aWy), .in_user(aUser),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_texel_matrix(aOutTex),
    .weights_matrix(aWm), .out_user(aOutUser), .out_sat(aSat), .out_weight_sum(aSum)
  );

  dc_ipu_filter_outer_product_nxm #(
    .TAPS_X(2), .TAPS_Y(6), .MUL_LATENCY(1), .ROUND_MODE(1), .SATURATE(0), .USER_WIDTH(4)
  ) dutB (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(bValid), .in_ready(bReady), .in_texel_matrix(bTex),
    .weights_x(bWx), .weights_y(bWy), .in_user(bUser),
    .out_valid(bOutValid), .out_ready(bcOutReady), .out_texel_matrix(bOutTex),
    .weights_matrix(bWm), .out_user(bOutUser), .out_sat(bSat), .out_weight_sum(bSum)
  );

  dc_ipu_filter_outer_product_nxm #(
    .TAPS_X(2), .TAPS_Y(6), .MUL_LATENCY(4), .ROUND_MODE(0), .SATURATE(1), .USER_WIDTH(4)
  ) dutC (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(bValid), .in_ready(cReady), .in_texel_matrix(bTex),
    .weights_x(bWx), .weights_y(bWy), .in_user(bUser),
    .out_valid(cOutValid), .out_ready(bcOutReady), .out_texel_matrix(cOutTex),
    .weights_matrix(cWm), .out_user(cOutUser), .out_sat(cSat), .out_weight_sum(cSum)
  );

  // single comparison point; every mismatch prints one FAIL line
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // one transfer into the default instance, then check its single output
  task automatic applyStimulus(input int n);
    int waited;
    @(negedge clk);
    for (int i = 0; i < 4; i++) aWx[i] = (i == 0) ? 12'(vecA[n].wx0) : 12'(vecA[n].wxR);
    for (int j = 0; j < 4; j++) aWy[j] = (j == 0) ? 12'(vecA[n].wy0) : 12'(vecA[n].wyR);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) aTex[i][j] = 24'(n * 256 + i * 16 + j);
    aUser     = 2'(n);
    aValid    = 1'b1;
    aOutReady = 1'b1;
    #1 checkOutput("A in_ready idle", aReady, 1);
    @(negedge clk);
    aValid = 1'b0;
    waited = 0;
    while (!aOutValid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("A latency", waited, 1);
    checkOutput("A w00", $signed(aWm[0][0]), vecA[n].e00);
    checkOutput("A w01", $signed(aWm[0][1]), vecA[n].e01);
    checkOutput("A w10", $signed(aWm[1][0]), vecA[n].e10);
    checkOutput("A w33", $signed(aWm[3][3]), vecA[n].e11);
    checkOutput("A sat", aSat, vecA[n].eSat);
    checkOutput("A sum", aSum, vecA[n].eSum);
    checkOutput("A texel", aOutTex[3][2], n * 256 + 3 * 16 + 2);
    checkOutput("A user", aOutUser, n % 4);
  endtask

  // one transfer onto the shared bus, checked at both 2x6 instances
  task automatic applyStimulusBC(input int n);
    int waited;
    @(negedge clk);
    for (int i = 0; i < 2; i++) bWx[i] = (i == 0) ? 12'(vecB[n].wx0) : 12'(vecB[n].wxR);
    for (int j = 0; j < 6; j++) bWy[j] = (j == 0) ? 12'(vecB[n].wy0) : 12'(vecB[n].wyR);
    bTex   = '0;
    bTex[1][5] = 24'(n + 40);
    bUser  = 4'(n);
    bValid = 1'b1;
    @(negedge clk);
    bValid = 1'b0;
    waited = 0;
    while (!bOutValid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("B latency", waited, 0);
    checkOutput("B w00", $signed(bWm[0][0]), vecB[n].e00);
    checkOutput("B w01", $signed(bWm[0][1]), vecB[n].e01);
    checkOutput("B w10", $signed(bWm[1][0]), vecB[n].e10);
    checkOutput("B w15", $signed(bWm[1][5]), vecB[n].e11);
    checkOutput("B sat", bSat, vecB[n].eSat);
    checkOutput("B sum", bSum, vecB[n].eSum);
    checkOutput("B texel", bOutTex[1][5], n + 40);
    waited = 0;
    while (!cOutValid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("C latency", waited, 3);
    checkOutput("C w00", $signed(cWm[0][0]), vecC[n].e00);
    checkOutput("C w01", $signed(cWm[0][1]), vecC[n].e01);
    checkOutput("C w10", $signed(cWm[1][0]), vecC[n].e10);
    checkOutput("C w15", $signed(cWm[1][5]), vecC[n].e11);
    checkOutput("C sat", cSat, vecC[n].eSat);
    checkOutput("C sum", cSum, vecC[n].eSum);
    checkOutput("C user", cOutUser, n);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent, recv, bRecv, cRecv, startEdge, occ;
    logic prevHold;
    logic [23:0] prevTex;
    logic [1:0]  prevUser;
    int staleSeen;

    // wx0, wxR, wy0, wyR, e00, e01, e10, e11, sat, sum  (default: truncate, saturate)
    vecA[0] = '{1024, 1024, 512, 512, 512, 512, 512, 512, 1'b0, 8192};
    vecA[1] = '{3, 1024, 512, 512, 1, 1, 512, 512, 1'b0, 6148};
    vecA[2] = '{-3, 1024, 512, 512, -2, -2, 512, 512, 1'b0, 6136};
    vecA[3] = '{-2048, 1024, -2048, 512, 2047, -1024, -2048, 512, 1'b1, -2561};
    vecA[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0};
    vecA[5] = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 1'b1, 32752};
    vecA[6] = '{-1024, -1024, 1024, 1024, -1024, -1024, -1024, -1024, 1'b0, -16384};
    // 2x6, round half up, wrap; e11 is element [1][5]
    vecB[0] = '{3, 1024, 512, 512, 2, 2, 512, 512, 1'b0, 3084};
    vecB[1] = '{-3, 1024, 512, 512, -1, -1, 512, 512, 1'b0, 3066};
    vecB[2] = '{-2048, 1024, -2048, 512, 0, -1024, -2048, 512, 1'b1, -4608};
    vecB[3] = '{2047, 2047, 2047, 2047, -4, -4, -4, -4, 1'b1, -48};
    // same inputs through the 2x6 truncate/saturate instance
    vecC[0] = '{3, 1024, 512, 512, 1, 1, 512, 512, 1'b0, 3078};
    vecC[1] = '{-3, 1024, 512, 512, -2, -2, 512, 512, 1'b0, 3060};
    vecC[2] = '{-2048, 1024, -2048, 512, 2047, -1024, -2048, 512, 1'b1, -2561};
    vecC[3] = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 1'b1, 24564};

    reset = 1'b1; clr = 1'b0;
    aValid = 1'b0; aOutReady = 1'b1; aTex = '0; aWx = '0; aWy = '0; aUser = '0;
    bValid = 1'b0; bcOutReady = 1'b1; bTex = '0; bWx = '0; bWy = '0; bUser = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", aOutValid, 0);
    checkOutput("reset in_ready", aReady, 0);
    checkOutput("reset sum", aSum, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("in_ready after reset", aReady, 1);

    $display("[TB] arithmetic vectors");
    for (int n = 0; n < 7; n++) applyStimulus(n);
    for (int n = 0; n < 4; n++) applyStimulusBC(n);

    $display("[TB] 2x6 continuous stream");
    for (int i = 0; i < 2; i++) bWx[i] = 12'd1024;
    for (int j = 0; j < 6; j++) bWy[j] = 12'd512;
    sent = 0; bRecv = 0; cRecv = 0; startEdge = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bOutValid) begin
        checkOutput("B stream order", bOutTex[0][0], bRecv);
        checkOutput("B stream timing", edgeCnt, startEdge + bRecv);
        bRecv++;
      end
      if (cOutValid) begin
        checkOutput("C stream order", cOutTex[0][0], cRecv);
        checkOutput("C stream timing", edgeCnt, startEdge + cRecv + 3);
        checkOutput("C stream sum", cSum, 6144);
        cRecv++;
      end
      if (sent < 8) begin
        if (sent == 0) startEdge = edgeCnt + 1;
        bValid = 1'b1;
        bTex[0][0] = 24'(sent);
        bUser = 4'(sent);
        #1;
        checkOutput("B in_ready stream", bReady, 1);
        checkOutput("C in_ready stream", cReady, 1);
        sent++;
      end else begin
        bValid = 1'b0;
      end
    end
    checkOutput("B stream count", bRecv, 8);
    checkOutput("C stream count", cRecv, 8);

    $display("[TB] backpressure stream");
    for (int i = 0; i < 4; i++) aWx[i] = 12'd1024;
    for (int j = 0; j < 4; j++) aWy[j] = 12'd512;
    aTex = '0;
    sent = 0; recv = 0; prevHold = 1'b0; prevTex = '0; prevUser = '0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      @(negedge clk);
      aOutReady = 1'(($urandom_range(0, 3) != 0) ? (cyc % 3 != 0) : 0);
      if (sent < 20) begin
        aValid = 1'b1;
        aTex[0][0] = 24'(sent);
        aUser = 2'(sent);
      end else begin
        aValid = 1'b0;
      end
      #1;
      occ = sent - recv;
      checkOutput("A in_ready vs fill", aReady, !(occ == 2 && !aOutReady));
      if (prevHold)
        checkOutput("A hold stable", {aOutValid, aOutTex[0][0], aOutUser}, {1'b1, prevTex, prevUser});
      if (aOutValid && aOutReady) begin
        checkOutput("A stream order", {aOutTex[0][0], aOutUser}, {24'(recv), 2'(recv)});
        recv++;
      end
      prevHold = aOutValid && !aOutReady;
      prevTex  = aOutTex[0][0];
      prevUser = aOutUser;
      if (aValid && aReady) sent++;
    end
    checkOutput("A stream count", recv, 20);
    @(negedge clk);
    aValid = 1'b0;
    aOutReady = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] flush then reset");
    aOutReady = 1'b0;
    aValid = 1'b1;
    aTex[0][0] = 24'd100;
    @(negedge clk);
    aTex[0][0] = 24'd101;
    @(negedge clk);
    clr = 1'b1;
    aTex[0][0] = 24'd102;
    #1;
    checkOutput("full before clr", {aOutValid, aOutTex[0][0]}, {1'b1, 24'd100});
    checkOutput("in_ready during clr", aReady, 0);
    @(negedge clk);
    clr = 1'b0;
    aValid = 1'b0;
    checkOutput("out_valid after clr", aOutValid, 0);
    aOutReady = 1'b1;
    staleSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (aOutValid) staleSeen++;
    end
    checkOutput("no stale after clr", staleSeen, 0);
    aValid = 1'b1;
    aTex[0][0] = 24'd200;
    @(negedge clk);
    aValid = 1'b0;
    @(negedge clk);
    checkOutput("restart item", {aOutValid, aOutTex[0][0]}, {1'b1, 24'd200});

    aOutReady = 1'b0;
    aValid = 1'b1;
    aTex[0][0] = 24'd300;
    @(negedge clk);
    aTex[0][0] = 24'd301;
    @(negedge clk);
    aValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst out_valid", aOutValid, 0);
    checkOutput("rst weights", |aWm, 0);
    checkOutput("rst texels", |aOutTex, 0);
    checkOutput("rst user", aOutUser, 0);
    checkOutput("rst sat", aSat, 0);
    checkOutput("rst sum", aSum, 0);
    checkOutput("rst in_ready", aReady, 0);
    @(negedge clk);
    reset = 1'b0;
    aOutReady = 1'b1;
    #1 checkOutput("in_ready after mid reset", aReady, 1);
    staleSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (aOutValid) staleSeen++;
    end
    checkOutput("no stale after reset", staleSeen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/dc_ipu_filter_outer_product_nxm.md
Name: dc_ipu_filter_outer_product_nxm

Overview:
Parametrised successor of the fixed 4x4 filter outer-product stage. It forms the TAPS_X x TAPS_Y separable weight matrix (wx[i]*wy[j]) with selectable rounding and saturation. The texel matrix and a user sideband travel through the same elastic valid/ready pipeline, so lockstep is guaranteed by construction. It sits between the texel fetch/weight generator and the filter MAC/accumulate stage.

Parameters:
RGB_WIDTH, 24, width of one texel word (passed through unmodified)
TAPS_X, 4, horizontal tap count (>=1)
TAPS_Y, 4, vertical tap count (>=1)
WEIGHT_WIDTH, 12, signed weight width, in and out
WEIGHT_FRACT_WIDTH, 10, fractional bits of weights (1 <= F < WEIGHT_WIDTH)
MUL_LATENCY, 2, pipeline depth in cycles (>=1)
ROUND_MODE, 0, 0 = truncate (floor), 1 = round half up
SATURATE, 1, 0 = wrap to WEIGHT_WIDTH, 1 = saturate
USER_WIDTH, 2, sideband width (e.g. line/frame markers)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
clr  in  1  synchronous pipeline flush
in_valid  in  1  input transfer valid
in_ready  out  1  input can be accepted
in_texel_matrix  in  RGB_WIDTH x [TAPS_X][TAPS_Y]  texel matrix
weights_x  in  signed WEIGHT_WIDTH x [TAPS_X]  horizontal weights
weights_y  in  signed WEIGHT_WIDTH x [TAPS_Y]  vertical weights
in_user  in  USER_WIDTH  sideband
out_valid  out  1  output transfer valid
out_ready  in  1  downstream accepts
out_texel_matrix  out  RGB_WIDTH x [TAPS_X][TAPS_Y]  delayed texels
weights_matrix  out  signed WEIGHT_WIDTH x [TAPS_X][TAPS_Y]  product matrix
out_user  out  USER_WIDTH  delayed sideband
out_sat  out  1  at least one element of this transfer saturated (wrapped if SATURATE=0)
out_weight_sum  out  signed WEIGHT_WIDTH+clog2(TAPS_X*TAPS_Y)  sum of weights_matrix elements (combinational from output registers)

Behaviour:
- Transfer = valid && ready on a rising edge, on both interfaces.
- Pipeline: MUL_LATENCY register stages, each with its own valid bit. Products, texels, user bits and sat flags advance together through one shared valid chain. No separate multiplier handshakes.
- A stage loads when its downstream stage is empty or is advancing in the same cycle. in_ready = !valid[0] || stage 0 advancing. Ready propagates combinationally back from out_ready.
- Throughput 1 transfer/cycle with out_ready held high. No bubbles are inserted.
- Latency: input accepted at edge k gives out_valid=1 after edge k+MUL_LATENCY-1 (stage-0 register output when MUL_LATENCY=1).
- Backpressure: with out_ready=0 the pipeline fills and holds. in_ready=0 once all stages are valid. Held outputs stay stable until accepted. No data loss or duplication.
- Arithmetic per element: p = wx[i]*wy[j], full 2*WEIGHT_WIDTH signed.
  - ROUND_MODE=1 adds 2^(F-1) before shifting.
  - Arithmetic right shift by F.
  - SATURATE=1 clamps to [-2^(W-1), 2^(W-1)-1]. SATURATE=0 keeps the low W bits.
  - The per-element overflow flag is set when the pre-clamp value falls outside that range. out_sat is the OR of all flags.
- Rounding and saturation complete in the first stage. Later stages only delay.
- out_weight_sum: signed sum of the final clamped or wrapped elements. It never overflows at the stated width.
- clr: clears every valid bit at the next edge and has priority over any load. A transfer presented in the same cycle is dropped, and in_ready reads 0 during clr. Data registers keep their contents.
- reset (asynchronous, active-high): all valid bits and data registers go to 0. out_valid=0, weights_matrix=0, out_texel_matrix=0, out_user=0, out_sat=0, out_weight_sum=0. in_ready=0 while reset is asserted and 1 in the first cycle after release. Reset mid-stream discards all in-flight data.

Test Plan:
1. Default parameters, wx[all]=1024 (1.0), wy[all]=512 (0.5), out_ready=1 -> after 2 cycles every weight=512, out_sat=0, out_weight_sum=8192, texels/user match input.
2. ROUND_MODE=0 vs 1, wx[0]=3, wy[0]=512 (product 1.5 LSB) -> weights_matrix[0][0]=1 (trunc) / 2 (round). wx[0]=-3 -> -2 (trunc) / -1 (round).
3. wx[0]=wy[0]=-2048 (-2.0) -> SATURATE=1 gives 2047, out_sat=1. SATURATE=0 gives 0, out_sat=1. All other elements unaffected.
4. Stream 20 transfers with incrementing in_user, out_ready toggling in a random pattern -> output order is 0..19 with no loss or duplication. in_ready drops only when MUL_LATENCY stages are full. Outputs stay stable while out_valid && !out_ready.
5. MUL_LATENCY=1 and 4, TAPS_X=2, TAPS_Y=6, continuous stream -> latency 1 / 4 cycles and full throughput.
6. clr pulse with 2 items in flight, then reset pulse mid-stream -> out_valid=0 next cycle, no stale output after restart, all outputs 0 during reset.
